// File: rtl/weight_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// weight_stream_ctrl_if
// Bundles the ROM read port and the output FIFO write port of the weight
// stream controller.
//   rom_address0    : ROM read address (controller -> ROM)
//   rom_ce0         : ROM read enable; data is valid on rom_q0 one cycle later
//   rom_q0          : ROM read data (ROM -> controller)
//   output_V_din    : stream data (controller -> FIFO)
//   output_V_full_n : FIFO not full (FIFO -> controller)
//   output_V_write  : stream write strobe (controller -> FIFO)
// Modports: master = controller side, slave = ROM/FIFO side.
// -----------------------------------------------------------------------------
interface weight_stream_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] rom_address0;
    logic                  rom_ce0;
    logic [DATA_WIDTH-1:0] rom_q0;
    logic [DATA_WIDTH-1:0] output_V_din;
    logic                  output_V_full_n;
    logic                  output_V_write;

    modport master (
        output rom_address0,
        output rom_ce0,
        input  rom_q0,
        output output_V_din,
        input  output_V_full_n,
        output output_V_write
    );

    modport slave (
        input  rom_address0,
        input  rom_ce0,
        output rom_q0,
        input  output_V_din,
        output output_V_full_n,
        input  output_V_write
    );
endinterface

// File: rtl/weight_stream_ctrl.sv
// -----------------------------------------------------------------------------
// weight_stream_ctrl
// Streams the contents of a weight ROM (MEM_SIZE words) num_passes times into a
// downstream FIFO. ROM reads are throttled so that a 2-entry skid buffer can
// never overflow, which lets the FIFO back-pressure at any time without loss.
//
// Ports:
//   ap_clk        : clock, all state on rising edge
//   ap_rst_n      : asynchronous active-low reset
//   start         : one-cycle start request, honoured only when idle
//   num_passes    : number of full ROM passes, sampled with start
//   busy          : high whenever not idle
//   done          : one-cycle pulse after the final word has been written
//   stall_cycles  : (only with WEIGHT_STALL_CNT_EN) saturating count of cycles
//                   with data waiting while the FIFO is full
//   bus           : ROM read port + FIFO write port (weight_stream_ctrl_if)
//
// Optional feature macro: WEIGHT_STALL_CNT_EN
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// FETCH | issuing ROM reads, address wraps per pass
// DRAIN | last read issued, emptying skid buffer and in-flight read
// -----------------------------------------------------------------------------
module weight_stream_ctrl #(
    parameter int MEM_SIZE   = 64,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 start,
    input  logic [15:0]          num_passes,
    output logic                 busy,
    output logic                 done,
`ifdef WEIGHT_STALL_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    weight_stream_ctrl_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           passes_left;
    logic                  done_q;

    logic                  rd_inflight;
    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            buf_count;

    logic                  buf_empty;
    logic                  pop;
    logic [2:0]            occ_next;
    logic                  rd_issue;
    logic                  last_read;

    assign buf_empty = (buf_count == 2'd0);
    assign pop       = !buf_empty && bus.output_V_full_n;

    // Occupancy next cycle before any new read: entries + in-flight - pop.
    // pop implies buf_count >= 1, so this never underflows.
    assign occ_next  = {1'b0, buf_count} + {2'b00, rd_inflight} - {2'b00, pop};

    // A new read is only issued if its data is guaranteed a free slot.
    assign rd_issue  = (state == S_FETCH) && (occ_next < 3'd2);
    assign last_read = rd_issue && (addr == LAST_ADDR) && (passes_left == 16'd1);

    assign busy                = (state != S_IDLE);
    assign done                = done_q;
    assign bus.rom_ce0         = rd_issue;
    assign bus.rom_address0    = addr;
    assign bus.output_V_din    = buf_mem[rd_ptr];
    assign bus.output_V_write  = pop;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            addr        <= '0;
            passes_left <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr        <= '0;
                        passes_left <= num_passes;
                        // Zero passes: acknowledge without ever leaving IDLE.
                        if (num_passes == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (rd_issue) begin
                        if (addr == LAST_ADDR) begin
                            addr        <= '0;
                            passes_left <= passes_left - 16'd1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                        if (last_read) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // No reads are issued here, so occ_next == 0 means the
                    // final word leaves the buffer this cycle.
                    if (occ_next == 3'd0) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_inflight <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            buf_count   <= 2'd0;
            buf_mem[0]  <= '0;
            buf_mem[1]  <= '0;
        end else begin
            rd_inflight <= rd_issue;
            if (rd_inflight) begin
                buf_mem[wr_ptr] <= bus.rom_q0;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            buf_count <= occ_next[1:0];
        end
    end

`ifdef WEIGHT_STALL_CNT_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_cycles <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cycles <= '0;
        end else if (!buf_empty && !bus.output_V_full_n && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
